imem_loader: RTL and testbench

Writable replacement for the single-cycle processor's fixed instruction ROM: a 64×N instruction RAM filled over a byte-serial load port, plus a controller that holds the CPU while a program loads. Sits between the external load source (UART/testbench) and the fetch stage. The fetch stage keeps its combinational `addr -> q` read path. The controller sequences header, data, optional checksum, zero-fill and run phases.

---
 rtl/imem_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Writable 64-word instruction RAM with a byte-serial loader that holds the CPU until a program is in place.
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
    parameter int N = 32,
    parameter logic [N-1:0] NOP = 32'h8b1f03ff
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_start,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         byte_ready,
    input  logic [5:0]   addr,
    output logic [N-1:0] q,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
`ifdef IMEM_LOAD_CHECKSUM_EN
        CHK,
`endif
        FILL,
        RUN,
        ERR
    } state_t;

    state_t       state;
    logic [6:0]   wcnt;
    logic [6:0]   nwords;
    logic [1:0]   bcnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]   xsum;
`endif
    logic [N-9:0] asm_word;
    logic [N-1:0] mem [0:63];

    logic         accept;
    logic         last_word;
    logic         wr_en;
    logic [N-1:0] shifted;

    assign accept    = byte_valid && byte_ready;
    assign shifted   = {asm_word, byte_data};
    assign last_word = (wcnt + 7'd1) == nwords;
    assign wr_en     = (state == DATA && accept && bcnt == 2'd3) || (state == FILL);

    // Fetch path stays combinational; the CPU only ever sees RAM once a load has completed.
    assign q = (state == RUN) ? mem[addr] : NOP;

    always_ff @(posedge clk) begin
        if (state == DATA && accept) begin
            asm_word <= shifted[N-9:0];
        end
        if (wr_en) begin
            mem[wcnt[5:0]] <= (state == FILL) ? '0 : shifted;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_hold   <= 1'b1;
            byte_ready <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            wcnt       <= '0;
            bcnt       <= '0;
            nwords     <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            xsum       <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE, RUN, ERR: begin
                    if (load_start) begin
                        state      <= HDR;
                        cpu_hold   <= 1'b1;
                        byte_ready <= 1'b1;
                        load_err   <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (byte_data != 8'd0 && byte_data <= 8'd64) begin
                            state  <= DATA;
                            nwords <= byte_data[6:0];
                            wcnt   <= '0;
                            bcnt   <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                            xsum   <= '0;
`endif
                        end else begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            load_err   <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        xsum <= xsum ^ byte_data;
`endif
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            wcnt <= wcnt + 7'd1;
                            if (last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                                state <= CHK;
`else
                                byte_ready <= 1'b0;
                                if (nwords == 7'd64) begin
                                    state     <= RUN;
                                    cpu_hold  <= 1'b0;
                                    load_done <= 1'b1;
                                end else begin
                                    state <= FILL;
                                end
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOAD_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        if (byte_data != xsum) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else if (nwords == 7'd64) begin
                            state     <= RUN;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
`endif
                FILL: begin
                    wcnt <= wcnt + 7'd1;
                    if (wcnt[5:0] == 6'd63) begin
                        state     <= RUN;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cpu_hold   <= 1'b1;
                    byte_ready <= 1'b0;
                    load_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads push expected fetch/status results, a monitor pops and compares.
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h8b1f03ff;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic [5:0]  addr = 6'd0;
    logic [31:0] q;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_loader #(.N(32), .NOP(NOP)) dut (
        .clk(clk),
        .reset(reset),
        .load_start(load_start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .addr(addr),
        .q(q),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] q;
        logic        hold;
        logic        err;
        logic        rdy;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    string       nm_q[$];
    logic        chk_vld = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [64];
    logic [7:0]  xs;
    int          cyc0;
    bit          toggle = 1'b0;

    // Monitor: pops one expectation for every cycle the stimulus flags as a check cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_underflow: got no expected entry, required one");
                end else begin
                    e  = sb.pop_front();
                    nm = nm_q.pop_front();
                    if (q !== e.q || cpu_hold !== e.hold || load_err !== e.err ||
                        byte_ready !== e.rdy || load_done !== e.done) begin
                        miscompares++;
                        $display("FAIL %s addr=%0d: got q=%h hold=%b err=%b rdy=%b done=%b, required q=%h hold=%b err=%b rdy=%b done=%b",
                                 nm, e.a, q, cpu_hold, load_err, byte_ready, load_done,
                                 e.q, e.hold, e.err, e.rdy, e.done);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic check(input string nm, input logic [5:0] a, input logic [31:0] eq,
                         input logic h, input logic e, input logic r, input logic d);
        addr = a;
        sb.push_back('{a: a, q: eq, hold: h, err: e, rdy: r, done: d});
        nm_q.push_back(nm);
        chk_vld = 1'b1;
        @(posedge clk); #1;
        chk_vld = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bit r;
        if (toggle) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk); #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
        cyc0 = cyc;
        if (!ok) cmp("byte_accept_timeout", 0, 1);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        xs = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b  = w[31-8*k -: 8];
            xs = xs ^ b;
            send_byte(b);
        end
    endtask

    task automatic finish_load(input int n);
        bit got = 1'b0;
        int dc = 0;
        logic hold_at = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(xs);
`endif
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (load_done) begin
                got     = 1'b1;
                dc      = cyc;
                hold_at = cpu_hold;
                break;
            end
        end
        cmp("load_done_seen", int'(got), 1);
        if (got) begin
            cmp("load_done_latency", dc - cyc0, 64 - n);
            cmp("hold_low_at_done", int'(hold_at), 0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) check($sformatf("readback_%0d", i), 6'(i), model[i], 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", 6'd7, NOP, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) check("idle_nop", 6'(i), NOP, 1'b1, 1'b0, 1'b0, 1'b0);

        // Two-word program, 62 fill cycles
        start_load();
        check("hdr_ready", 6'd0, NOP, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        model[0] = 32'hf8000001;
        model[1] = 32'h8b050083;
        send_byte(8'h02);
        send_word(model[0]);
        send_word(model[1]);
        finish_load(2);

        // Re-hold from RUN, then bad headers
        start_load();
        check("rehold", 6'd0, NOP, 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'h00);
        check("err_hdr00", 6'd1, NOP, 1'b1, 1'b1, 1'b0, 1'b0);
        check("err_hdr00_stays", 6'd0, NOP, 1'b1, 1'b1, 1'b0, 1'b0);
        start_load();
        check("err_exit", 6'd0, NOP, 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'h41);
        check("err_hdr41", 6'd2, NOP, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOAD_CHECKSUM_EN
        // Wrong checksum: correct value would be 44
        start_load();
        send_byte(8'h01);
        send_word(32'h11223344);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) check("bad_checksum_err", 6'd0, NOP, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        // Full 64-word load with byte_valid toggling
        start_load();
        toggle = 1'b1;
        send_byte(8'h40);
        for (int i = 0; i < 64; i++) begin
            model[i] = {8'(i), 8'(i * 3 + 1), 8'(~i), 8'h5a};
            send_word(model[i]);
        end
        finish_load(64);
        toggle = 1'b0;

        // Reset in the middle of DATA, then a clean single-word reload
        start_load();
        send_byte(8'h01);
        send_byte(8'hb4);
        send_byte(8'h00);
        send_byte(8'h00);
        reset = 1'b0;
        check("reset_mid_data", 6'd0, NOP, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        check("after_reset", 6'd0, NOP, 1'b1, 1'b0, 1'b0, 1'b0);
        start_load();
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        model[0] = 32'hb400001f;
        send_byte(8'h01);
        send_word(model[0]);
        finish_load(1);

        repeat (2) @(posedge clk);
        cmp("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
